// File: rtl/lc3_mem_seq.sv
// LC-3 memory-path sequencer: steps fetch, load and store transactions through
// ADDR / DATA / MEM / FIN. Define MEM_TIMEOUT_EN to abort MEM after TIMEOUT_CYCLES waits.
module lc3_mem_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Start,
  input  logic [1:0] i_Op,
  input  logic       i_Mem_R,
  output logic       o_LD_MAR,
  output logic       o_LD_MDR,
  output logic       o_LD_IR,
  output logic       o_LD_PC,
  output logic       o_Gate_PC,
  output logic       o_Gate_Addr,
  output logic       o_Gate_SR,
  output logic       o_Gate_MDR,
  output logic       o_MIO_Sel,
  output logic       o_MEM_EN,
  output logic       o_R_W,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_MEM,
    S_FIN
  } state_e;

  typedef enum logic [1:0] {
    OP_FETCH = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic   timeout;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_q, wait_d;

  // Abort is decided from the registered count so o_Err stays a clean state decode.
  assign timeout = (state_q == S_MEM) && (wait_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    wait_d = wait_q;
    if (state_q != S_MEM && state_d == S_MEM) begin
      wait_d = '0;
    end else if (state_q == S_MEM && !i_Mem_R && !timeout) begin
      wait_d = wait_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
      op_q    <= OP_FETCH;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic.
  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_Start && op_e'(i_Op) != OP_RSVD) begin
          op_d    = op_e'(i_Op);
          state_d = S_ADDR;
        end
      end
      S_ADDR:  state_d = (op_q == OP_STORE) ? S_DATA : S_MEM;
      S_DATA:  state_d = S_MEM;
      S_MEM: begin
        if (timeout) begin
          state_d = S_IDLE;
        end else if (i_Mem_R) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: Moore on state/op, except o_LD_MDR which follows i_Mem_R in MEM.
  always_comb begin
    o_LD_MAR    = 1'b0;
    o_LD_MDR    = 1'b0;
    o_LD_IR     = 1'b0;
    o_LD_PC     = 1'b0;
    o_Gate_PC   = 1'b0;
    o_Gate_Addr = 1'b0;
    o_Gate_SR   = 1'b0;
    o_Gate_MDR  = 1'b0;
    o_MIO_Sel   = 1'b0;
    o_MEM_EN    = 1'b0;
    o_R_W       = 1'b0;
    o_Done      = 1'b0;
    o_Err       = 1'b0;
    o_Busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_ADDR: begin
        o_LD_MAR = 1'b1;
        if (op_q == OP_FETCH) begin
          o_Gate_PC = 1'b1;
          o_LD_PC   = 1'b1;
        end else begin
          o_Gate_Addr = 1'b1;
        end
      end
      S_DATA: begin
        o_Gate_SR = 1'b1;
        o_LD_MDR  = 1'b1;
      end
      S_MEM: begin
        if (timeout) begin
          o_Err = 1'b1;
        end else begin
          o_MEM_EN = 1'b1;
          if (op_q == OP_STORE) begin
            o_R_W = 1'b1;
          end else begin
            o_MIO_Sel = 1'b1;
            o_LD_MDR  = i_Mem_R;
          end
        end
      end
      S_FIN: begin
        o_Done = 1'b1;
        if (op_q != OP_STORE) o_Gate_MDR = 1'b1;
        if (op_q == OP_FETCH) o_LD_IR = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
